// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring, 32 steps).
// Define MUL_DIV_FAST_EN to let special cases and |rs1| < |rs2| skip the iteration.
module mul_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] dvd_q, dvs_q, quot_q, rem_q, spec_res_q, result_q;
  logic [4:0]      cnt_q;
  logic            is_rem_q, neg_quot_q, neg_rem_q, special_q;

  logic            accept, is_signed, sgn1, sgn2, div0, ovf, special;
  logic [XLEN-1:0] mag1, mag2, spec_res;
  logic [XLEN:0]   rem_sh, trial;
  logic            qbit;
  logic [XLEN-1:0] rem_step, quot_step, quot_fix, rem_fix, final_res;

  // Operand decode at accept: signs, magnitudes and the overriding special results
  assign accept    = (state_q == S_IDLE) && in_valid && !flush;
  assign is_signed = ~div_op[0];
  assign sgn1      = is_signed & rs1[XLEN-1];
  assign sgn2      = is_signed & rs2[XLEN-1];
  assign mag1      = sgn1 ? -rs1 : rs1;
  assign mag2      = sgn2 ? -rs2 : rs2;
  assign div0      = (rs2 == '0);
  assign ovf       = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign special   = div0 | ovf;
  assign spec_res  = div0 ? (div_op[1] ? rs1 : '1)
                          : (div_op[1] ? '0  : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MUL_DIV_FAST_EN
  logic            bypass;
  logic [XLEN-1:0] bypass_res;
  assign bypass     = special || (mag1 < mag2);
  assign bypass_res = special ? spec_res : (div_op[1] ? rs1 : '0);
`endif

  // One restoring step; the shifted remainder needs XLEN+1 bits when the divisor is >= 2^(XLEN-1)
  assign rem_sh    = {rem_q, dvd_q[XLEN-1]};
  assign trial     = rem_sh - {1'b0, dvs_q};
  assign qbit      = ~trial[XLEN];
  assign rem_step  = qbit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_step = {quot_q[XLEN-2:0], qbit};
  assign quot_fix  = neg_quot_q ? -quot_step : quot_step;
  assign rem_fix   = neg_rem_q ? -rem_step : rem_step;
  assign final_res = special_q ? spec_res_q : (is_rem_q ? rem_fix : quot_fix);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef MUL_DIV_FAST_EN
          state_d = bypass ? S_DONE : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt_q == 5'd0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    result    = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else if (accept) begin
      dvd_q      <= mag1;
      dvs_q      <= mag2;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= 5'd31;
      is_rem_q   <= div_op[1];
      neg_quot_q <= sgn1 ^ sgn2;
      neg_rem_q  <= sgn1;
      special_q  <= special;
      spec_res_q <= spec_res;
`ifdef MUL_DIV_FAST_EN
      if (bypass) result_q <= bypass_res;
`endif
    end else if ((state_q == S_CALC) && !flush) begin
      dvd_q  <= {dvd_q[XLEN-2:0], 1'b0};
      rem_q  <= rem_step;
      quot_q <= quot_step;
      cnt_q  <= cnt_q - 5'd1;
      // Result register is written exactly once, on the count-0 step
      if (cnt_q == 5'd0) result_q <= final_res;
    end
  end

endmodule

// File: doc/mul_div_iter.md
# mul_div_iter

Iterative RV32M divide unit; completes the M-extension datapath alongside the combinational multiply E-stage. Accepts one DIV/DIVU/REM/REMU operation per handshake, runs a radix-2 restoring division over 32 cycles on operand magnitudes, applies RISC-V sign and special-case rules, and holds the 32-bit result until the writeback side accepts it. Sits in the execute stage; the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  abort the in-flight op and discard any held result.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `div_op`  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0]).
- `rs1`  in  32  dividend.
- `rs2`  in  32  divisor.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- `busy`  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. When `in_valid` is high and `flush` is low, latch `div_op`, the operand signs, and the magnitudes `|rs1|` and `|rs2|`. Magnitudes apply only to signed ops; unsigned ops use the raw values. Then clear the 32-bit quotient shift register and the 33-bit partial remainder, load the count to 31, and go to CALC.
- CALC, each cycle:
  - Shift the partial remainder left by 1 and bring in the next dividend MSB.
  - Compute trial = remainder − divisor. If trial ≥ 0, commit it and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the count. After the count-0 step, go to DONE.
- DONE: the result register is loaded. Hold `out_valid`=1 until `out_ready`=1, then go to IDLE.
- Sign fix for DIV: negate the quotient if signs differ.
- Sign fix for REM: negate the remainder if the dividend is negative.
- Special cases are detected at accept and override the computed value:
  - Divisor 0: quotient = 0xFFFF_FFFF for both DIV and DIVU; remainder = `rs1` unmodified.
  - Signed overflow (rs1=0x8000_0000, rs2=0xFFFF_FFFF, DIV/REM): quotient = 0x8000_0000, remainder = 0.
- `flush` in any state: go to IDLE next cycle and drop `out_valid`. Flush with `in_valid` in the same cycle: flush wins and nothing is accepted.
- `in_valid` outside IDLE is ignored. `rs1`, `rs2` and `div_op` are sampled only on the accept edge.
- All internal arithmetic is unsigned on magnitudes. The 33-bit remainder prevents trial overflow when the divisor is ≥ 2^31.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, count=0.
- Accept edge at cycle N:
  - CALC occupies cycles N+1..N+32.
  - `out_valid` rises at N+33 (full path).
- Result handoff:
  - `out_ready` high in the first DONE cycle: `in_ready` returns at N+34.
  - Back-to-back throughput: one op per 34 cycles.
- `result` is stable while `out_valid`=1.
- Reset mid-CALC: all outputs take their reset values on the next edge; no result is produced.

## Configuration
- `MUL_DIV_FAST_EN` defined: the special cases plus the trivial case `|rs1| < |rs2|` bypass CALC. For the trivial case, quotient = 0 and remainder = `rs1`. State goes IDLE→DONE and `out_valid` rises at N+1.
- `MUL_DIV_FAST_EN` undefined: every op takes the full 33-cycle path. Special-case results are muxed in when DONE is entered, so latency is deterministic.

## Test plan
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2 → `result`=0xFFFF_FFFD (-3); REM on the same operands → 0xFFFF_FFFF (-1); `out_valid` at N+33.
- DIVU rs1=0xFFFF_FFFF, rs2=0x8000_0000 → 1; REMU on the same operands → 0x7FFF_FFFF. Exercises the 33-bit remainder.
- Divide-by-zero: DIV rs1=-7, rs2=0 → 0xFFFF_FFFF; REM → 0xFFFF_FFF9. With `MUL_DIV_FAST_EN`, `out_valid` at N+1.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM on the same operands → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. `result` stays constant and `in_ready`=0 throughout; release → `in_ready`=1 next cycle.
- Assert `flush` at N+10 (mid-CALC), and separately `rst` at N+10 → IDLE next cycle, `out_valid` never rises. A new op is then accepted and returns the correct result.
